// File: rtl/data_collector_pkg.sv
// Shared definitions for the three-to-one data collector.
//   - Source-tag constants, identical to the 2-bit distributor's FUN codes,
//     so a downstream distributor can route replies straight from OUT_SRC.
//   - Output-register state encoding.
package data_collector_pkg;

    localparam logic [1:0] SRC_NONE = 2'b00;
    localparam logic [1:0] SRC_1    = 2'b01;
    localparam logic [1:0] SRC_2    = 2'b10;
    localparam logic [1:0] SRC_3    = 2'b11;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/rr_arbiter_3.sv
// Three-request round-robin arbiter.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   req[2:0]      request per source (bit 0 = source 1)
//   upd           load the pointer with upd_src this cycle
//   upd_src[1:0]  tag (1..3) of the source just granted
//   gnt[2:0]      one-hot grant, combinational from req and the pointer
// The pointer holds the tag of the last granted source; the search starts
// at pointer+1 and wraps 3 -> 1. Reset value 3 gives source 1 first priority.
module rr_arbiter_3
    import data_collector_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req,
    input  logic       upd,
    input  logic [1:0] upd_src,
    output logic [2:0] gnt
);

    logic [1:0] ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)      ptr <= SRC_3;
        else if (upd) ptr <= upd_src;
    end

    always_comb begin
        gnt = 3'b000;
        case (ptr)
            SRC_1: begin            // order 2, 3, 1
                if      (req[1]) gnt = 3'b010;
                else if (req[2]) gnt = 3'b100;
                else if (req[0]) gnt = 3'b001;
            end
            SRC_2: begin            // order 3, 1, 2
                if      (req[2]) gnt = 3'b100;
                else if (req[0]) gnt = 3'b001;
                else if (req[1]) gnt = 3'b010;
            end
            default: begin          // SRC_3 (SRC_NONE never loaded): 1, 2, 3
                if      (req[0]) gnt = 3'b001;
                else if (req[1]) gnt = 3'b010;
                else if (req[2]) gnt = 3'b100;
            end
        endcase
    end

endmodule

// File: rtl/data_collector_2b.sv
// Three-to-one data collector with a one-entry registered output.
// Ports:
//   CLK, RST                   clock, asynchronous active-high reset
//   FUN[1:0]                   01/10/11 force source 1/2/3, 00 automatic
//   IN_x, VALID_x, READY_x     source channels x = 1..3 (valid/ready)
//   OUT, OUT_SRC, OUT_VALID    held word, its source tag, occupancy
//   OUT_READY                  consumer takes the held word this cycle
// Build option: DATA_COLLECTOR_RR_EN enables round-robin arbitration when
// FUN=00; without it FUN=00 grants nothing and no arbiter is built.
module data_collector_2b
    import data_collector_pkg::*;
#(
    parameter int WIDTH = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [1:0]       FUN,
    input  logic [WIDTH-1:0] IN_1,
    input  logic [WIDTH-1:0] IN_2,
    input  logic [WIDTH-1:0] IN_3,
    input  logic             VALID_1,
    input  logic             VALID_2,
    input  logic             VALID_3,
    output logic             READY_1,
    output logic             READY_2,
    output logic             READY_3,
    output logic [WIDTH-1:0] OUT,
    output logic [1:0]       OUT_SRC,
    output logic             OUT_VALID,
    input  logic             OUT_READY
);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] data_q, data_nxt, sel_data;
    logic [1:0]       src_q, src_nxt, sel_src;
    logic [2:0]       valid, grant, ready, rr_gnt;
    logic             can_accept, xfer;

    assign valid = {VALID_3, VALID_2, VALID_1};

`ifdef DATA_COLLECTOR_RR_EN
    // Pointer only advances on automatic-mode transfers; forced grants
    // leave the round-robin order untouched.
    rr_arbiter_3 u_arb (
        .clk     (CLK),
        .rst     (RST),
        .req     (valid),
        .upd     (xfer && (FUN == SRC_NONE)),
        .upd_src (sel_src),
        .gnt     (rr_gnt)
    );
`else
    assign rr_gnt = 3'b000;
`endif

    always_comb begin
        grant = 3'b000;
        case (FUN)
            SRC_1:   grant[0] = valid[0];
            SRC_2:   grant[1] = valid[1];
            SRC_3:   grant[2] = valid[2];
            default: grant    = rr_gnt;
        endcase
    end

    // FULL with OUT_READY allows drain-and-refill in one cycle. RST gates
    // READY because the register reads EMPTY throughout reset.
    assign can_accept = (state == EMPTY) || OUT_READY;
    assign ready      = grant & {3{can_accept && !RST}};
    assign xfer       = |ready;

    assign READY_1 = ready[0];
    assign READY_2 = ready[1];
    assign READY_3 = ready[2];

    always_comb begin
        sel_data = '0;
        sel_src  = SRC_NONE;
        if (grant[0]) begin
            sel_data = IN_1;
            sel_src  = SRC_1;
        end else if (grant[1]) begin
            sel_data = IN_2;
            sel_src  = SRC_2;
        end else if (grant[2]) begin
            sel_data = IN_3;
            sel_src  = SRC_3;
        end
    end

    always_comb begin
        state_nxt = state;
        data_nxt  = data_q;
        src_nxt   = src_q;
        if (xfer) begin
            state_nxt = FULL;
            data_nxt  = sel_data;
            src_nxt   = sel_src;
        end else if (state == FULL && OUT_READY) begin
            // Drained: OUT keeps its last value, only the tag clears.
            state_nxt = EMPTY;
            src_nxt   = SRC_NONE;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= EMPTY;
            data_q <= '0;
            src_q  <= SRC_NONE;
        end else begin
            state  <= state_nxt;
            data_q <= data_nxt;
            src_q  <= src_nxt;
        end
    end

    assign OUT       = data_q;
    assign OUT_SRC   = src_q;
    assign OUT_VALID = (state == FULL);

endmodule

// File: tb/tb_data_collector_2b.sv
// Scoreboard bench for data_collector_2b: the driver pushes the word it
// expects to be delivered; a monitor pops and compares on every output
// handshake (OUT_VALID & OUT_READY) sampled on the falling edge.
module tb_data_collector_2b;

    logic       CLK = 1'b0;
    logic       RST;
    logic [1:0] FUN;
    logic [1:0] IN_1, IN_2, IN_3;
    logic       VALID_1, VALID_2, VALID_3;
    logic       READY_1, READY_2, READY_3;
    logic [1:0] OUT;
    logic [1:0] OUT_SRC;
    logic       OUT_VALID;
    logic       OUT_READY;

    typedef struct {
        logic [1:0] d;
        logic [1:0] s;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    data_collector_2b #(.WIDTH(2)) dut (
        .CLK(CLK), .RST(RST), .FUN(FUN),
        .IN_1(IN_1), .IN_2(IN_2), .IN_3(IN_3),
        .VALID_1(VALID_1), .VALID_2(VALID_2), .VALID_3(VALID_3),
        .READY_1(READY_1), .READY_2(READY_2), .READY_3(READY_3),
        .OUT(OUT), .OUT_SRC(OUT_SRC), .OUT_VALID(OUT_VALID),
        .OUT_READY(OUT_READY)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [1:0] d, input logic [1:0] s);
        exp_t e;
        e.d = d;
        e.s = s;
        q.push_back(e);
    endtask

    task automatic step;
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [2:0] rdy;
        return {READY_3, READY_2, READY_1};
    endfunction

    // Monitor
    always @(negedge CLK) begin
        if (!RST && OUT_VALID && OUT_READY) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_word: got %0h/%0h want none", OUT, OUT_SRC);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("out_data", {30'd0, OUT}, {30'd0, e.d});
                chk("out_src", {30'd0, OUT_SRC}, {30'd0, e.s});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset with a would-be grant present: READY must stay low.
        RST = 1'b1; FUN = 2'b10; OUT_READY = 1'b1;
        IN_1 = 2'b00; IN_2 = 2'b11; IN_3 = 2'b00;
        VALID_1 = 1'b0; VALID_2 = 1'b1; VALID_3 = 1'b0;
        #3;
        chk("rst_ready", {29'd0, rdy()}, 32'h0);
        chk("rst_valid", {31'd0, OUT_VALID}, 32'h0);
        chk("rst_out", {30'd0, OUT}, 32'h0);
        chk("rst_src", {30'd0, OUT_SRC}, 32'h0);
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        #1;

        // Forced source 2
        chk("t1_ready", {29'd0, rdy()}, 32'h2);
        push(2'b11, 2'b10);
        step;
        VALID_2 = 1'b0;
        @(negedge CLK);
        chk("t1_out_valid", {31'd0, OUT_VALID}, 32'h1);
        step;

        // Forced source 1 not valid, source 3 valid: nothing granted
        FUN = 2'b01; VALID_3 = 1'b1; IN_3 = 2'b01;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("t2_ready", {29'd0, rdy()}, 32'h0);
            chk("t2_out_valid", {31'd0, OUT_VALID}, 32'h0);
            step;
        end

        // Backpressure
        VALID_3 = 1'b0; VALID_1 = 1'b1; IN_1 = 2'b10; OUT_READY = 1'b0;
        @(negedge CLK);
        chk("t3_first_ready", {29'd0, rdy()}, 32'h1);
        push(2'b10, 2'b01);
        step;
        IN_1 = 2'b01;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            chk("t3_hold_out", {30'd0, OUT}, 32'h2);
            chk("t3_hold_src", {30'd0, OUT_SRC}, 32'h1);
            chk("t3_hold_valid", {31'd0, OUT_VALID}, 32'h1);
            chk("t3_hold_ready", {29'd0, rdy()}, 32'h0);
            step;
        end
        OUT_READY = 1'b1;
        #1;
        chk("t3_release_ready", {29'd0, rdy()}, 32'h1);
        push(2'b01, 2'b01);
        step;
        VALID_1 = 1'b0;
        @(negedge CLK);
        chk("t3_refill_valid", {31'd0, OUT_VALID}, 32'h1);
        step;

        // Automatic mode, all sources valid
        FUN = 2'b00; IN_1 = 2'b01; IN_2 = 2'b10; IN_3 = 2'b11;
        VALID_1 = 1'b1; VALID_2 = 1'b1; VALID_3 = 1'b1;
`ifdef DATA_COLLECTOR_RR_EN
        #1;
        chk("rr_ready0", {29'd0, rdy()}, 32'h1); push(2'b01, 2'b01); step;
        chk("rr_ready1", {29'd0, rdy()}, 32'h2); push(2'b10, 2'b10); step;
        chk("rr_ready2", {29'd0, rdy()}, 32'h4); push(2'b11, 2'b11); step;
        chk("rr_ready3", {29'd0, rdy()}, 32'h1); push(2'b01, 2'b01); step;
        VALID_1 = 1'b0; VALID_2 = 1'b0; VALID_3 = 1'b0;
        step;
`else
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            chk("rr_off_ready", {29'd0, rdy()}, 32'h0);
            chk("rr_off_valid", {31'd0, OUT_VALID}, 32'h0);
            step;
        end
        VALID_1 = 1'b0; VALID_2 = 1'b0; VALID_3 = 1'b0;
`endif

        // Async reset while FULL: held word is lost
        FUN = 2'b10; VALID_2 = 1'b1; IN_2 = 2'b10; OUT_READY = 1'b0;
        @(negedge CLK);
        chk("t5_ready", {29'd0, rdy()}, 32'h2);
        step;
        VALID_2 = 1'b0; FUN = 2'b00;
        @(negedge CLK);
        chk("t5_full_out", {30'd0, OUT}, 32'h2);
        chk("t5_full_valid", {31'd0, OUT_VALID}, 32'h1);
        #1;
        RST = 1'b1;
        #1;
        chk("t5_rst_out", {30'd0, OUT}, 32'h0);
        chk("t5_rst_src", {30'd0, OUT_SRC}, 32'h0);
        chk("t5_rst_valid", {31'd0, OUT_VALID}, 32'h0);
        @(negedge CLK);
        RST = 1'b0;
        OUT_READY = 1'b1;
`ifdef DATA_COLLECTOR_RR_EN
        VALID_1 = 1'b1; VALID_2 = 1'b1; VALID_3 = 1'b1;
        #1;
        chk("t5_rr_first", {29'd0, rdy()}, 32'h1);
        push(2'b01, 2'b01);
        step;
        VALID_1 = 1'b0; VALID_2 = 1'b0; VALID_3 = 1'b0;
`endif
        step;
        step;
        chk("queue_empty", q.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
